multicycle_control: RTL and testbench

Multicycle successor to the single-cycle MIPS control decoder. A state machine sequences each instruction through fetch, decode, execute, memory and write-back. Instruction-fetch and data accesses are stretched with a MOC (memory operation complete) handshake, so slow RAM is supported. It sits between the instruction register and the datapath and drives the same control signals as the single-cycle decoder, plus sequencing strobes (ir_load, pc_inc) and fault flags.

---
 rtl/mcu_pkg.sv | 70 +++++++
 rtl/mcu_decoder.sv | 51 +++++
 rtl/multicycle_control.sv | 173 +++++++++++++++++
 tb/tb_multicycle_control.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// Optional MOC timeout is enabled with MCU_MOC_TIMEOUT_EN.
package mcu_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_IDLE   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_SPEC2 = 6'b011100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SB    = 6'b101000;

    localparam logic [4:0] ALU_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_SPEC2 = 5'b00001;
    localparam logic [4:0] ALU_LW    = 5'b01000;
    localparam logic [4:0] ALU_LHU   = 5'b01001;
    localparam logic [4:0] ALU_LB    = 5'b01010;
    localparam logic [4:0] ALU_LH    = 5'b01011;
    localparam logic [4:0] ALU_SW    = 5'b01101;
    localparam logic [4:0] ALU_SH    = 5'b01110;
    localparam logic [4:0] ALU_SB    = 5'b01111;
    localparam logic [4:0] ALU_BEQ   = 5'b10000;
    localparam logic [4:0] ALU_BGTZ  = 5'b10101;
    localparam logic [4:0] ALU_BLEZ  = 5'b10110;
    localparam logic [4:0] ALU_J     = 5'b00000;

    typedef struct packed {
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src;
        logic [4:0] alu_fnc;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jump;
        logic       writes_reg;
        logic       legal;
    } ctrl_t;

    // Loads and stores share the immediate-offset address path.
    function automatic ctrl_t mem_cw(input logic [4:0] fnc, input logic ld);
        ctrl_t c;
        c            = '0;
        c.alu_src    = 1'b1;
        c.alu_fnc    = fnc;
        c.is_load    = ld;
        c.is_store   = ~ld;
        c.mem_to_reg = ld;
        c.writes_reg = ld;
        c.legal      = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/mcu_decoder.sv
// Combinational opcode to control-word decoder.
// Unknown opcodes return a word with legal cleared.
module mcu_decoder
    import mcu_pkg::*;
(
    input  logic [5:0] opcode_i,
    output ctrl_t      cw_o
);

    always_comb begin
        cw_o       = '0;
        cw_o.legal = 1'b1;
        case (opcode_i)
            OP_RTYPE: begin
                cw_o.reg_dst    = 1'b1;
                cw_o.writes_reg = 1'b1;
                cw_o.alu_fnc    = ALU_RTYPE;
            end
            OP_SPEC2: begin
                cw_o.reg_dst    = 1'b1;
                cw_o.writes_reg = 1'b1;
                cw_o.alu_fnc    = ALU_SPEC2;
            end
            OP_J: begin
                cw_o.is_jump = 1'b1;
                cw_o.alu_fnc = ALU_J;
            end
            OP_BEQ: begin
                cw_o.is_branch = 1'b1;
                cw_o.alu_fnc   = ALU_BEQ;
            end
            OP_BGTZ: begin
                cw_o.is_branch = 1'b1;
                cw_o.alu_fnc   = ALU_BGTZ;
            end
            OP_BLEZ: begin
                cw_o.is_branch = 1'b1;
                cw_o.alu_fnc   = ALU_BLEZ;
            end
            OP_LW:   cw_o = mem_cw(ALU_LW, 1'b1);
            OP_LHU:  cw_o = mem_cw(ALU_LHU, 1'b1);
            OP_LB:   cw_o = mem_cw(ALU_LB, 1'b1);
            OP_LH:   cw_o = mem_cw(ALU_LH, 1'b1);
            OP_SW:   cw_o = mem_cw(ALU_SW, 1'b0);
            OP_SH:   cw_o = mem_cw(ALU_SH, 1'b0);
            OP_SB:   cw_o = mem_cw(ALU_SB, 1'b0);
            default: cw_o.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with MOC-stretched memory accesses.
// Define MCU_MOC_TIMEOUT_EN to trap on a MOC wait longer than TIMEOUT_CYCLES.
module multicycle_control
    import mcu_pkg::*;
#(
    parameter int ALU_FNC_W      = 5,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic                 MOC,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 alu_src,
    output logic [ALU_FNC_W-1:0] alu_fnc,
    output logic                 reg_write,
    output logic                 RAMEnable,
    output logic                 RW,
    output logic                 MOV,
    output logic                 jump,
    output logic                 branch,
    output logic                 ir_load,
    output logic                 pc_inc,
    output logic                 illegal_op,
    output logic                 bus_error,
    output logic [2:0]           state
);

    if (ALU_FNC_W < 5) begin : g_bad_fnc_w
        $error("ALU_FNC_W must be at least 5");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_to
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_t state_q, state_d;
    ctrl_t  cw_q, cw_d, dec_cw;
    logic   illegal_q, illegal_d;
    logic   to_hit;

    mcu_decoder u_dec (
        .opcode_i (opcode),
        .cw_o     (dec_cw)
    );

`ifdef MCU_MOC_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
    logic [7:0] cnt_q, cnt_d;
    logic       bus_q, bus_d;

    assign to_hit    = (cnt_q + 8'd1) == TO_LIM;
    assign bus_error = bus_q;

    // Any state change restarts the wait count for the next request.
    always_comb begin
        cnt_d = cnt_q;
        bus_d = bus_q;
        if (state_d != state_q) begin
            cnt_d = 8'd0;
        end else if ((state_q == S_FETCH || state_q == S_MEM) && !MOC) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (state_d == S_TRAP && state_q != S_TRAP && !illegal_d) begin
            bus_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
            bus_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            bus_q <= bus_d;
        end
    end
`else
    assign to_hit    = 1'b0;
    assign bus_error = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cw_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cw_q      <= cw_d;
            illegal_q <= illegal_d;
        end
    end

    assign state      = state_q;
    assign illegal_op = illegal_q;

    always_comb begin
        state_d    = state_q;
        cw_d       = cw_q;
        illegal_d  = illegal_q;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_fnc    = '0;
        reg_write  = 1'b0;
        RAMEnable  = 1'b0;
        RW         = 1'b0;
        MOV        = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                RAMEnable = 1'b1;
                RW        = 1'b1;
                MOV       = 1'b1;
                if (MOC) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end else if (to_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                cw_d = dec_cw;
                if (!dec_cw.legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src = cw_q.alu_src;
                alu_fnc = ALU_FNC_W'(cw_q.alu_fnc);
                if (cw_q.is_jump) begin
                    jump    = 1'b1;
                    state_d = S_FETCH;
                end else if (cw_q.is_branch) begin
                    branch  = 1'b1;
                    state_d = S_FETCH;
                end else if (cw_q.is_load || cw_q.is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                RAMEnable = 1'b1;
                MOV       = 1'b1;
                RW        = cw_q.is_load;
                if (MOC) begin
                    state_d = cw_q.is_load ? S_WB : S_FETCH;
                end else if (to_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                reg_write  = cw_q.writes_reg;
                reg_dst    = cw_q.reg_dst;
                mem_to_reg = cw_q.mem_to_reg;
                state_d    = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle expected
// output stream built from instruction-level phase schedules.
module tb_multicycle_control;

    typedef struct packed {
        logic [2:0] st;
        logic       rd;
        logic       m2r;
        logic       asrc;
        logic [4:0] fnc;
        logic       rwen;
        logic       ram;
        logic       rw;
        logic       mov;
        logic       jmp;
        logic       br;
        logic       irl;
        logic       pci;
        logic       ill;
        logic       bus;
    } ob_t;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       MOC;
    logic       reg_dst, mem_to_reg, alu_src;
    logic [4:0] alu_fnc;
    logic       reg_write, RAMEnable, RW, MOV;
    logic       jump, branch, ir_load, pc_inc;
    logic       illegal_op, bus_error;
    logic [2:0] state;

    int    checks;
    int    errors;
    ob_t   expq[$];
    string tagq[$];
    int    n;

    multicycle_control #(
        .ALU_FNC_W      (5),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .MOC        (MOC),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .alu_fnc    (alu_fnc),
        .reg_write  (reg_write),
        .RAMEnable  (RAMEnable),
        .RW         (RW),
        .MOV        (MOV),
        .jump       (jump),
        .branch     (branch),
        .ir_load    (ir_load),
        .pc_inc     (pc_inc),
        .illegal_op (illegal_op),
        .bus_error  (bus_error),
        .state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction-set model: classes and ALU codes straight from the opcode table.
    function automatic logic is_r(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b011100;
    endfunction
    function automatic logic is_ld(input logic [5:0] op);
        return op == 6'b100011 || op == 6'b100101 ||
               op == 6'b100000 || op == 6'b100001;
    endfunction
    function automatic logic is_st(input logic [5:0] op);
        return op == 6'b101011 || op == 6'b101001 || op == 6'b101000;
    endfunction
    function automatic logic is_br(input logic [5:0] op);
        return op == 6'b000100 || op == 6'b000110 || op == 6'b000111;
    endfunction
    function automatic logic [4:0] spec_alu(input logic [5:0] op);
        case (op)
            6'b011100: return 5'b00001;
            6'b100011: return 5'b01000;
            6'b100101: return 5'b01001;
            6'b100000: return 5'b01010;
            6'b100001: return 5'b01011;
            6'b101011: return 5'b01101;
            6'b101001: return 5'b01110;
            6'b101000: return 5'b01111;
            6'b000100: return 5'b10000;
            6'b000111: return 5'b10101;
            6'b000110: return 5'b10110;
            default:   return 5'b00000;
        endcase
    endfunction

    function automatic ob_t blank(input logic [2:0] st);
        ob_t o;
        o    = '0;
        o.st = st;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // One clock cycle: set MOC, queue this cycle's expected outputs.
    task automatic step(input logic moc, input ob_t e, input string tag);
        MOC = moc;
        expq.push_back(e);
        tagq.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int fw, input logic [5:0] op, input string tag);
        ob_t e;
        opcode = op;
        e      = blank(3'd0);
        e.ram  = 1'b1;
        e.rw   = 1'b1;
        e.mov  = 1'b1;
        for (int i = 0; i < fw; i++) step(1'b0, e, tag);
        e.irl = 1'b1;
        e.pci = 1'b1;
        step(1'b1, e, tag);
    endtask

    // Full instruction; cyc returns how many cycles the model scheduled.
    task automatic instr(input logic [5:0] op, input int fw, input int mw,
                         input logic idle_moc, input string tag,
                         output int cyc);
        ob_t e;
        cyc = fw + 1;
        fetch(fw, op, tag);
        step(idle_moc, blank(3'd1), tag);
        cyc++;
        opcode = op ^ 6'h3f;
        e      = blank(3'd2);
        e.asrc = is_ld(op) || is_st(op);
        e.fnc  = spec_alu(op);
        e.jmp  = op == 6'b000010;
        e.br   = is_br(op);
        step(idle_moc, e, tag);
        cyc++;
        if (is_ld(op) || is_st(op)) begin
            e     = blank(3'd3);
            e.ram = 1'b1;
            e.mov = 1'b1;
            e.rw  = is_ld(op);
            for (int i = 0; i < mw; i++) step(1'b0, e, tag);
            step(1'b1, e, tag);
            cyc += mw + 1;
        end
        if (is_r(op) || is_ld(op)) begin
            e      = blank(3'd4);
            e.rwen = 1'b1;
            e.rd   = is_r(op);
            e.m2r  = is_ld(op);
            step(idle_moc, e, tag);
            cyc++;
        end
    endtask

    task automatic hold_reset(input int k);
        reset = 1'b1;
        for (int i = 0; i < k; i++) step(1'b0, blank(3'd6), "reset");
        reset = 1'b0;
        step(1'b0, blank(3'd6), "release");
    endtask

    always @(negedge clk) begin
        ob_t   e;
        ob_t   a;
        string t;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            t = tagq.pop_front();
            a = {state, reg_dst, mem_to_reg, alu_src, alu_fnc, reg_write,
                 RAMEnable, RW, MOV, jump, branch, ir_load, pc_inc,
                 illegal_op, bus_error};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s @%0t: got %h want %h", t, $time, a, e);
            end
        end
    end

    initial begin
        ob_t e;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        MOC    = 1'b0;
        opcode = 6'b000000;
        @(posedge clk);
        #1;
        chk("reset_state", 32'(state), 32'd6);
        chk("reset_mov", 32'(MOV), 32'd0);
        hold_reset(2);

        instr(6'b000000, 0, 0, 1'b1, "add", n);
        chk("add_cycles", 32'(n), 32'd4);
        instr(6'b100011, 0, 3, 1'b0, "lw_slow", n);
        chk("lw_slow_cycles", 32'(n), 32'd8);
        instr(6'b101000, 1, 0, 1'b0, "sb", n);
        chk("sb_cycles", 32'(n), 32'd5);
        chk("sb_alu_code", 32'(spec_alu(6'b101000)), 32'h0f);
        instr(6'b000010, 0, 0, 1'b0, "j", n);
        chk("j_cycles", 32'(n), 32'd3);
        instr(6'b011100, 0, 0, 1'b1, "special2", n);
        instr(6'b000100, 2, 0, 1'b0, "beq", n);
        instr(6'b000110, 0, 0, 1'b1, "blez", n);
        instr(6'b000111, 0, 0, 1'b0, "bgtz", n);
        instr(6'b100101, 0, 0, 1'b0, "lhu", n);
        chk("lhu_cycles", 32'(n), 32'd5);
        instr(6'b100000, 0, 1, 1'b0, "lb", n);
        instr(6'b100001, 0, 0, 1'b0, "lh", n);
        instr(6'b101011, 0, 0, 1'b0, "sw", n);
        chk("sw_cycles", 32'(n), 32'd4);
        instr(6'b101001, 0, 2, 1'b0, "sh", n);

        // Reset dropped into the middle of a pending load.
        fetch(0, 6'b100011, "lw_abort");
        step(1'b0, blank(3'd1), "lw_abort");
        e      = blank(3'd2);
        e.asrc = 1'b1;
        e.fnc  = 5'b01000;
        step(1'b0, e, "lw_abort");
        MOC = 1'b0;
        chk("abort_mov_before", 32'(MOV), 32'd1);
        chk("abort_state_before", 32'(state), 32'd3);
        #1 reset = 1'b1;
        #1;
        chk("abort_mov", 32'(MOV), 32'd0);
        chk("abort_ram", 32'(RAMEnable), 32'd0);
        chk("abort_regw", 32'(reg_write), 32'd0);
        chk("abort_state", 32'(state), 32'd6);
        expq.push_back(blank(3'd6));
        tagq.push_back("abort");
        @(posedge clk);
        #1;
        hold_reset(1);
        instr(6'b000000, 0, 0, 1'b0, "add_after_abort", n);

        // Unknown opcode locks in TRAP regardless of MOC.
        fetch(0, 6'b111111, "illegal");
        step(1'b0, blank(3'd1), "illegal");
        e     = blank(3'd7);
        e.ill = 1'b1;
        for (int i = 0; i < 20; i++) step(1'(i), e, "trap");
        chk("trap_illegal", 32'(illegal_op), 32'd1);
        hold_reset(1);

`ifdef MCU_MOC_TIMEOUT_EN
        e     = blank(3'd0);
        e.ram = 1'b1;
        e.rw  = 1'b1;
        e.mov = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, e, "to_fetch");
        e     = blank(3'd7);
        e.bus = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, e, "to_trap");
        chk("to_state", 32'(state), 32'd7);
        chk("to_bus", 32'(bus_error), 32'd1);
`else
        e     = blank(3'd0);
        e.ram = 1'b1;
        e.rw  = 1'b1;
        e.mov = 1'b1;
        for (int i = 0; i < 100; i++) step(1'b0, e, "wait_fetch");
        chk("wait_state", 32'(state), 32'd0);
        chk("wait_bus", 32'(bus_error), 32'd0);
`endif

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
